// File: rtl/fifo_pkg.sv
// Shared definitions for the programmable synchronous FIFO: read-mode enum and a
// width helper usable in parameter expressions.
package fifo_pkg;

  typedef enum logic {
    FIFO_REG_READ = 1'b0,
    FIFO_FWFT     = 1'b1
  } fifo_read_mode_e;

  // Bits needed to encode values 0..value-1; returns at least 1.
  function automatic int fifo_clog2(input int value);
    int w;
    w = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      w++;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy and flag logic for the programmable FIFO. Pointers wrap by
// explicit compare so depths that are not powers of two work.
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = fifo_clog2(FIFO_DEPTH + 1),
  parameter int PTR_W      = fifo_clog2(FIFO_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic             flush,
  input  logic [CNT_W-1:0] af_thresh,
  input  logic [CNT_W-1:0] ae_thresh,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             almostfull,
  output logic             almostempty,
  output logic             wr_accept,
  output logic             rd_accept,
  output logic             wr_reject,
  output logic             rd_reject
);

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  // Flush masks both requests, so nothing is accepted or rejected that cycle.
  assign wr_accept = wr_en & ~full & ~flush;
  assign rd_accept = rd_en & ~empty & ~flush;
  assign wr_reject = wr_en & full & ~flush;
  assign rd_reject = rd_en & empty & ~flush;

  // A zero threshold, or an almost-full threshold at or beyond depth, disables the flag.
  assign almostfull  = (af_thresh != '0) && (af_thresh < DEPTH_C) &&
                       (count >= af_thresh) && !full;
  assign almostempty = (ae_thresh != '0) && !empty && (count <= ae_thresh);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_accept) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_accept) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_accept, rd_accept})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with parametrised width/depth, registered or first-word-fall-through
// read, runtime almost-full/almost-empty thresholds and synchronous flush.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int FWFT       = 0,
  parameter int CNT_W      = fifo_clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  input  logic                  flush,
  input  logic [CNT_W-1:0]      af_thresh,
  input  logic [CNT_W-1:0]      ae_thresh,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PTR_W = fifo_clog2(FIFO_DEPTH);

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  wr_accept;
  logic                  rd_accept;
  logic                  wr_reject;
  logic                  rd_reject;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  fifo_ptr_ctrl #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W),
    .PTR_W      (PTR_W)
  ) u_ptr_ctrl (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .flush       (flush),
    .af_thresh   (af_thresh),
    .ae_thresh   (ae_thresh),
    .wr_ptr      (wr_ptr),
    .rd_ptr      (rd_ptr),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almostfull  (almostfull),
    .almostempty (almostempty),
    .wr_accept   (wr_accept),
    .rd_accept   (rd_accept),
    .wr_reject   (wr_reject),
    .rd_reject   (rd_reject)
  );

  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ack    <= wr_accept;
      overflow  <= wr_reject;
      underflow <= rd_reject;
    end
  end

  generate
    if (FWFT == int'(FIFO_FWFT)) begin : g_fwft
      // Gated on empty so stale (unreset) memory never shows on data_out.
      assign data_out = empty ? '0 : mem[rd_ptr];
      assign rd_valid = ~empty;
    end else begin : g_reg_read
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_out <= '0;
          rd_valid <= 1'b0;
        end else begin
          rd_valid <= rd_accept;
          if (rd_accept) data_out <= mem[rd_ptr];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: three instances (depth 8 registered, depth 5 registered,
// depth 8 FWFT) share one stimulus stream and are checked against queue models.
module tb_sync_fifo_prog;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] din = '0;
  logic [3:0]  af = '0;
  logic [3:0]  ae = '0;
  logic [2:0]  af5;
  logic [2:0]  ae5;

  logic [15:0] dout [3];
  logic        rv [3], fl [3], em [3], afl [3], ael [3], wack [3], ovf [3], udf [3];
  logic [3:0]  cnt0, cnt2;
  logic [2:0]  cnt1;

  int n_checks = 0;
  int n_fail   = 0;

  assign af5 = af[2:0];
  assign ae5 = ae[2:0];

  always #5 clk = ~clk;

  sync_fifo_prog #(.DATA_WIDTH(16), .FIFO_DEPTH(8), .FWFT(0)) u_d8 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(din), .rd_en(rd_en), .flush(flush),
    .af_thresh(af), .ae_thresh(ae), .data_out(dout[0]), .rd_valid(rv[0]), .count(cnt0),
    .full(fl[0]), .empty(em[0]), .almostfull(afl[0]), .almostempty(ael[0]),
    .wr_ack(wack[0]), .overflow(ovf[0]), .underflow(udf[0]));

  sync_fifo_prog #(.DATA_WIDTH(16), .FIFO_DEPTH(5), .FWFT(0)) u_d5 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(din), .rd_en(rd_en), .flush(flush),
    .af_thresh(af5), .ae_thresh(ae5), .data_out(dout[1]), .rd_valid(rv[1]), .count(cnt1),
    .full(fl[1]), .empty(em[1]), .almostfull(afl[1]), .almostempty(ael[1]),
    .wr_ack(wack[1]), .overflow(ovf[1]), .underflow(udf[1]));

  sync_fifo_prog #(.DATA_WIDTH(16), .FIFO_DEPTH(8), .FWFT(1)) u_fw (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(din), .rd_en(rd_en), .flush(flush),
    .af_thresh(af), .ae_thresh(ae), .data_out(dout[2]), .rd_valid(rv[2]), .count(cnt2),
    .full(fl[2]), .empty(em[2]), .almostfull(afl[2]), .almostempty(ael[2]),
    .wr_ack(wack[2]), .overflow(ovf[2]), .underflow(udf[2]));

  function automatic int dep(input int i);
    return (i == 1) ? 5 : 8;
  endfunction

  function automatic bit is_fwft(input int i);
    return (i == 2);
  endfunction

  // Thresholds as seen by each instance (the depth-5 one has 3-bit ports).
  function automatic int thr(input int i, input logic [3:0] t);
    logic [2:0] t3;
    t3 = t[2:0];
    return (i == 1) ? int'(t3) : int'(t);
  endfunction

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h at %0t", name, inst, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue per instance plus the registered handshake outputs.
  logic [15:0] mq [3][$];
  logic [15:0] m_dout [3] = '{16'h0, 16'h0, 16'h0};
  bit          m_rv [3]   = '{0, 0, 0};
  bit          m_wack [3] = '{0, 0, 0};
  bit          m_ovf [3]  = '{0, 0, 0};
  bit          m_udf [3]  = '{0, 0, 0};

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      int n;
      bit wa, ra;
      logic [15:0] h;
      n = mq[i].size();
      if (!rst_n) begin
        mq[i].delete();
        m_dout[i] = '0;
        m_rv[i] = 0; m_wack[i] = 0; m_ovf[i] = 0; m_udf[i] = 0;
      end else if (flush) begin
        mq[i].delete();
        m_rv[i] = 0; m_wack[i] = 0; m_ovf[i] = 0; m_udf[i] = 0;
      end else begin
        wa = wr_en && (n < dep(i));
        ra = rd_en && (n > 0);
        if (ra) begin
          h = mq[i].pop_front();
          if (!is_fwft(i)) m_dout[i] = h;
        end
        if (!is_fwft(i)) m_rv[i] = ra;
        if (wa) mq[i].push_back(din);
        m_wack[i] = wa;
        m_ovf[i]  = wr_en && (n == dep(i));
        m_udf[i]  = rd_en && (n == 0);
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int n, a, b;
      logic [31:0] ac;
      bit e_af, e_ae, e_rv;
      logic [15:0] e_dout;
      n = mq[i].size();
      a = thr(i, af);
      b = thr(i, ae);
      e_af = (a != 0) && (a < dep(i)) && (n >= a) && (n < dep(i));
      e_ae = (n > 0) && (n <= b);
      e_rv = is_fwft(i) ? (n > 0) : m_rv[i];
      e_dout = is_fwft(i) ? ((n > 0) ? mq[i][0] : 16'h0) : m_dout[i];
      ac = (i == 0) ? 32'(cnt0) : (i == 1) ? 32'(cnt1) : 32'(cnt2);
      chk("count", i, ac, 32'(n));
      chk("full", i, 32'(fl[i]), 32'(n == dep(i)));
      chk("empty", i, 32'(em[i]), 32'(n == 0));
      chk("almostfull", i, 32'(afl[i]), 32'(e_af));
      chk("almostempty", i, 32'(ael[i]), 32'(e_ae));
      chk("wr_ack", i, 32'(wack[i]), 32'(m_wack[i]));
      chk("overflow", i, 32'(ovf[i]), 32'(m_ovf[i]));
      chk("underflow", i, 32'(udf[i]), 32'(m_udf[i]));
      chk("rd_valid", i, 32'(rv[i]), 32'(e_rv));
      chk("data_out", i, 32'(dout[i]), 32'(e_dout));
    end
  end

  task automatic step(input logic w, input logic [15:0] d, input logic r, input logic f);
    wr_en = w; din = d; rd_en = r; flush = f;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    af = 4'd6;
    ae = 4'd2;
    #3 rst_n = 1'b0;
    #1;
    chk("reset_count", 0, 32'(cnt0), 32'd0);
    chk("reset_empty", 0, 32'(em[0]), 32'd1);
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Fill depth-8 with 1..8, then one rejected write.
    for (int k = 1; k <= 8; k++) step(1'b1, 16'(k), 1'b0, 1'b0);
    chk("fill_count", 0, 32'(cnt0), 32'd8);
    chk("fill_full", 0, 32'(fl[0]), 32'd1);
    chk("fill_wr_ack", 0, 32'(wack[0]), 32'd1);
    step(1'b1, 16'h0009, 1'b0, 1'b0);
    chk("ovf_flag", 0, 32'(ovf[0]), 32'd1);
    chk("ovf_wr_ack", 0, 32'(wack[0]), 32'd0);
    chk("ovf_count", 0, 32'(cnt0), 32'd8);
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 16'h0, 1'b1, 1'b0);
      chk("drain_data", 0, 32'(dout[0]), 32'(k));
      chk("drain_valid", 0, 32'(rv[0]), 32'd1);
    end
    step(1'b0, 16'h0, 1'b0, 1'b0);
    chk("idle_valid", 0, 32'(rv[0]), 32'd0);

    // Threshold change at count 5 takes effect in the same cycle.
    for (int k = 0; k < 5; k++) step(1'b1, 16'(16'h0040 + k), 1'b0, 1'b0);
    wr_en = 1'b0;
    #1;
    chk("af_before", 0, 32'(afl[0]), 32'd0);
    af = 4'd3;
    #1;
    chk("af_after", 0, 32'(afl[0]), 32'd1);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    af = 4'd6;

    // Flush together with a write at count 5.
    step(1'b1, 16'h0055, 1'b0, 1'b1);
    chk("flush_count", 0, 32'(cnt0), 32'd0);
    chk("flush_empty", 0, 32'(em[0]), 32'd1);
    chk("flush_wr_ack", 0, 32'(wack[0]), 32'd0);

    // Simultaneous write/read on empty, then on full.
    step(1'b1, 16'hBEEF, 1'b1, 1'b0);
    chk("empty_rw_ack", 0, 32'(wack[0]), 32'd1);
    chk("empty_rw_udf", 0, 32'(udf[0]), 32'd1);
    chk("empty_rw_count", 0, 32'(cnt0), 32'd1);
    for (int k = 0; k < 7; k++) step(1'b1, 16'(16'h0010 + k), 1'b0, 1'b0);
    step(1'b1, 16'h1234, 1'b1, 1'b0);
    chk("full_rw_ovf", 0, 32'(ovf[0]), 32'd1);
    chk("full_rw_head", 0, 32'(dout[0]), 32'hBEEF);
    chk("full_rw_valid", 0, 32'(rv[0]), 32'd1);

    // FWFT: word visible the cycle after the write without any read.
    step(1'b0, 16'h0, 1'b0, 1'b1);
    step(1'b1, 16'h00AA, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    chk("fwft_valid", 2, 32'(rv[2]), 32'd1);
    chk("fwft_data", 2, 32'(dout[2]), 32'h00AA);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    chk("fwft_pop_empty", 2, 32'(em[2]), 32'd1);
    chk("fwft_pop_valid", 2, 32'(rv[2]), 32'd0);

    // Depth-5 wrap: preload 3, then 12 write/read pairs.
    step(1'b0, 16'h0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b1, 16'(16'h0200 + k), 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) step(1'b1, 16'(16'h0300 + k), 1'b1, 1'b0);
    chk("wrap_last_data", 1, 32'(dout[1]), 32'h0308);
    chk("wrap_count", 1, 32'(cnt1), 32'd3);

    // Mixed burst with varying thresholds and occasional flush.
    for (int k = 0; k < 40; k++) begin
      af = 4'($urandom_range(0, 9));
      ae = 4'($urandom_range(0, 8));
      step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 15) == 0));
    end
    for (int k = 0; k < 6; k++) step(1'b1, 16'(16'h0700 + k), 1'b0, 1'b0);

    // Reset mid-burst must clear outputs without a clock edge.
    wr_en = 1'b1;
    rd_en = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 0, 32'(cnt0), 32'd0);
    chk("arst_empty", 0, 32'(em[0]), 32'd1);
    chk("arst_full", 0, 32'(fl[0]), 32'd0);
    chk("arst_wr_ack", 0, 32'(wack[0]), 32'd0);
    chk("arst_rd_valid", 0, 32'(rv[0]), 32'd0);
    chk("arst_data", 0, 32'(dout[0]), 32'd0);
    chk("arst_fwft_valid", 2, 32'(rv[2]), 32'd0);
    chk("arst_fwft_data", 2, 32'(dout[2]), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    step(1'b1, 16'h0ABC, 1'b1, 1'b0);
    chk("post_rst_udf", 0, 32'(udf[0]), 32'd1);
    chk("post_rst_count", 0, 32'(cnt0), 32'd1);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
